// File: rtl/fetch_decode_unit.sv
// -----------------------------------------------------------------------------
// fetch_decode_unit
//   Fetches 32-bit instructions as two 16-bit half-words (high half first),
//   decodes the two-bit operation class, dispatches arithmetic instructions to
//   an execution unit (EU) with a one-cycle strobe and waits for the EU to
//   finish. NOP words are skipped; a HALT word parks the unit until start.
//
// Optional feature macro: EU_TIMEOUT_EN
//   Defined   : an 8-bit counter bounds the EU wait; after 255 WAIT_EU cycles
//               without completion err is set (sticky) and the unit halts.
//   Undefined : the EU wait is unbounded and err is tied low.
//
// Ports
//   clk       in   1   clock, all state changes on the rising edge
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   begin/resume fetching (honoured in IDLE and HALTED only)
//   mem_addr  out  16  registered word address (the PC)
//   mem_rd    out  1   read request, high in FETCH_HI/FETCH_LO
//   mem_ack   in   1   mem_data valid; only meaningful while mem_rd=1
//   mem_data  in   16  instruction half-word
//   ir        out  32  instruction register
//   sel_eu    out  2   EU operation class (00 arith-imm, 01 arith-reg)
//   cs        out  1   EU dispatch strobe, one-cycle pulse
//   ready1    in   1   EU ready, low while busy
//   halt      out  1   high in HALTED
//   err       out  1   sticky EU-timeout flag
// -----------------------------------------------------------------------------
module fetch_decode_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [31:0] ir,
  output logic [1:0]  sel_eu,
  output logic        cs,
  input  logic        ready1,
  output logic        halt,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_HI = 3'd1,
    S_FETCH_LO = 3'd2,
    S_DECODE   = 3'd3,
    S_DISPATCH = 3'd4,
    S_WAIT_EU  = 3'd5,
    S_HALTED   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  sel_eu_q, sel_eu_d;
  logic        saw_low_q, saw_low_d;
  logic        mem_rd_q;
  logic        cs_q;
  logic        halt_q;
  logic        eu_done_s;
`ifdef EU_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
`endif

  // The EU has finished only after it was seen busy in WAIT_EU and is ready again;
  // a ready1 that is already high on entry does not count.
  assign eu_done_s = saw_low_q & ready1;

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    sel_eu_d  = sel_eu_q;
    saw_low_d = saw_low_q;
`ifdef EU_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_HI: begin
        if (mem_ack) begin
          ir_d[31:16] = mem_data;
          pc_d        = pc_q + 16'd1;
          state_d     = S_FETCH_LO;
        end else begin
          state_d = S_FETCH_HI;
        end
      end
      S_FETCH_LO: begin
        if (mem_ack) begin
          ir_d[15:0] = mem_data;
          pc_d       = pc_q + 16'd1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH_LO;
        end
      end
      S_DECODE: begin
        case (ir_q[31:30])
          2'b00: begin
            sel_eu_d = 2'b00;
            state_d  = S_DISPATCH;
          end
          2'b01: begin
            sel_eu_d = 2'b01;
            state_d  = S_DISPATCH;
          end
          2'b10:   state_d = S_FETCH_HI;
          2'b11:   state_d = S_HALTED;
          default: state_d = S_IDLE;
        endcase
      end
      S_DISPATCH: begin
        saw_low_d = 1'b0;
`ifdef EU_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
        state_d   = S_WAIT_EU;
      end
      S_WAIT_EU: begin
        if (eu_done_s) begin
          state_d = S_FETCH_HI;
        end else begin
          if (!ready1) begin
            saw_low_d = 1'b1;
          end else begin
            saw_low_d = saw_low_q;
          end
`ifdef EU_TIMEOUT_EN
          // Counter value 254 marks the 255th cycle spent waiting.
          if (tmo_cnt_q == 8'd254) begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            state_d   = S_WAIT_EU;
          end
`else
          state_d = S_WAIT_EU;
`endif
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_FETCH_HI;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      sel_eu_q  <= 2'b00;
      saw_low_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      cs_q      <= 1'b0;
      halt_q    <= 1'b0;
`ifdef EU_TIMEOUT_EN
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      sel_eu_q  <= sel_eu_d;
      saw_low_q <= saw_low_d;
      // Strobes are decoded from the next state so they line up with state_q.
      mem_rd_q  <= (state_d == S_FETCH_HI) || (state_d == S_FETCH_LO);
      cs_q      <= (state_d == S_DISPATCH);
      halt_q    <= (state_d == S_HALTED);
`ifdef EU_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign mem_addr = pc_q;
  assign mem_rd   = mem_rd_q;
  assign ir       = ir_q;
  assign sel_eu   = sel_eu_q;
  assign cs       = cs_q;
  assign halt     = halt_q;
`ifdef EU_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit. Instance u_dut uses RESET_PC=0000,
// instance u_dut_w uses RESET_PC=FFFF for the address wrap scenario. Each
// instance has its own memory handshake model with a programmable ack delay.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, b_start, ready1, b_ready1;
  logic [15:0] mem_addr, mem_data, b_mem_addr, b_mem_data;
  logic        mem_rd, mem_ack, b_mem_rd, b_mem_ack;
  logic [31:0] ir, b_ir;
  logic [1:0]  sel_eu, b_sel_eu;
  logic        cs, b_cs, halt, b_halt, err, b_err;

  logic [15:0] mem [0:255];
  int a_delay = 0, b_delay = 0, a_wait = 0, b_wait = 0;
  int cs_cnt = 0, cs_snap = 0;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  fetch_decode_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_data(mem_data), .ir(ir), .sel_eu(sel_eu), .cs(cs),
    .ready1(ready1), .halt(halt), .err(err)
  );

  fetch_decode_unit #(.RESET_PC(16'hFFFF)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd),
    .mem_ack(b_mem_ack), .mem_data(b_mem_data), .ir(b_ir), .sel_eu(b_sel_eu), .cs(b_cs),
    .ready1(b_ready1), .halt(b_halt), .err(b_err)
  );

  // Memory model: ack after 'delay' wait cycles of a held read request
  assign mem_data   = mem[mem_addr[7:0]];
  assign b_mem_data = mem[b_mem_addr[7:0]];
  assign mem_ack    = mem_rd && (a_wait >= a_delay);
  assign b_mem_ack  = b_mem_rd && (b_wait >= b_delay);

  always @(posedge clk) begin
    if (!mem_rd || mem_ack) a_wait <= 0; else a_wait <= a_wait + 1;
    if (!b_mem_rd || b_mem_ack) b_wait <= 0; else b_wait <= b_wait + 1;
    if (cs) cs_cnt <= cs_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; b_start = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1;
    tick; tick;
    total_cnt++; if (mem_addr !== 16'h0000) $display("FAIL rst_addr got %h exp 0000", mem_addr); else pass_cnt++;
    total_cnt++; if (b_mem_addr !== 16'hFFFF) $display("FAIL rst_addr_w got %h exp ffff", b_mem_addr); else pass_cnt++;
    total_cnt++; if ({mem_rd, cs, halt, err} !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", {mem_rd, cs, halt, err}); else pass_cnt++;
    total_cnt++; if (ir !== 32'h0) $display("FAIL rst_ir got %h exp 0", ir); else pass_cnt++;
    total_cnt++; if (sel_eu !== 2'b00) $display("FAIL rst_sel got %b exp 00", sel_eu); else pass_cnt++;
    start = 1'b0; rst_n = 1'b1;
    tick;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL rst_idle got %b exp 0", mem_rd); else pass_cnt++;
  endtask

  task automatic test_arith_imm;
    mem[0] = 16'h0012; mem[1] = 16'h3456;
    a_delay = 0; ready1 = 1'b1;
    do_reset;
    cs_snap = cs_cnt;
    start = 1'b1; tick; start = 1'b0;
    total_cnt++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL imm_hi got rd=%b addr=%h exp rd=1 addr=0000", mem_rd, mem_addr); else pass_cnt++;
    tick;
    total_cnt++; if (mem_addr !== 16'h0001 || cs !== 1'b0) $display("FAIL imm_lo got addr=%h cs=%b exp addr=0001 cs=0", mem_addr, cs); else pass_cnt++;
    tick;
    total_cnt++; if (ir !== 32'h0012_3456) $display("FAIL imm_ir got %h exp 00123456", ir); else pass_cnt++;
    total_cnt++; if (cs !== 1'b0 || mem_rd !== 1'b0) $display("FAIL imm_decode got cs=%b rd=%b exp 0 0", cs, mem_rd); else pass_cnt++;
    tick;
    total_cnt++; if (cs !== 1'b1 || sel_eu !== 2'b00) $display("FAIL imm_dispatch got cs=%b sel=%b exp cs=1 sel=00", cs, sel_eu); else pass_cnt++;
    tick;
    total_cnt++; if (cs !== 1'b0) $display("FAIL imm_cs_drop got %b exp 0", cs); else pass_cnt++;
    total_cnt++; if (cs_cnt - cs_snap !== 1) $display("FAIL imm_cs_width got %0d exp 1", cs_cnt - cs_snap); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0002) $display("FAIL imm_addr_after got %h exp 0002", mem_addr); else pass_cnt++;
    tick; tick; tick;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL imm_ready_high_entry got rd=%b exp 0", mem_rd); else pass_cnt++;
  endtask

  task automatic test_arith_reg;
    mem[0] = 16'h4ABC; mem[1] = 16'h0001;
    a_delay = 0; ready1 = 1'b1;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    total_cnt++; if (cs !== 1'b1 || sel_eu !== 2'b01) $display("FAIL reg_dispatch got cs=%b sel=%b exp cs=1 sel=01", cs, sel_eu); else pass_cnt++;
    tick;
    start = 1'b1; tick; tick; start = 1'b0;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL reg_start_ignored got rd=%b exp 0", mem_rd); else pass_cnt++;
    ready1 = 1'b0;
    tick; tick; tick;
    total_cnt++; if (mem_rd !== 1'b0 || ir !== 32'h4ABC_0001 || sel_eu !== 2'b01) $display("FAIL reg_busy got rd=%b ir=%h sel=%b exp 0 4abc0001 01", mem_rd, ir, sel_eu); else pass_cnt++;
    ready1 = 1'b1;
    tick;
    total_cnt++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) $display("FAIL reg_refetch got rd=%b addr=%h exp 1 0002", mem_rd, mem_addr); else pass_cnt++;
  endtask

  task automatic test_nop_halt;
    mem[0] = 16'h8000; mem[1] = 16'h0000; mem[2] = 16'hC000; mem[3] = 16'h0000;
    a_delay = 0; ready1 = 1'b1;
    do_reset;
    cs_snap = cs_cnt;
    start = 1'b1; tick; start = 1'b0;
    repeat (6) tick;
    total_cnt++; if (halt !== 1'b1 || mem_addr !== 16'h0004) $display("FAIL halt_state got halt=%b addr=%h exp 1 0004", halt, mem_addr); else pass_cnt++;
    tick;
    total_cnt++; if (cs_cnt - cs_snap !== 0 || mem_rd !== 1'b0) $display("FAIL halt_no_cs got cs_cnt=%0d rd=%b exp 0 0", cs_cnt - cs_snap, mem_rd); else pass_cnt++;
    start = 1'b1; tick; start = 1'b0;
    total_cnt++; if (halt !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0004) $display("FAIL halt_resume got halt=%b rd=%b addr=%h exp 0 1 0004", halt, mem_rd, mem_addr); else pass_cnt++;
  endtask

  task automatic test_wrap;
    mem[255] = 16'h1234; mem[0] = 16'h3456;
    b_delay = 2; b_ready1 = 1'b1;
    do_reset;
    b_start = 1'b1; tick; b_start = 1'b0;
    total_cnt++; if (b_mem_rd !== 1'b1 || b_mem_addr !== 16'hFFFF || b_mem_ack !== 1'b0) $display("FAIL wrap_hi got rd=%b addr=%h ack=%b exp 1 ffff 0", b_mem_rd, b_mem_addr, b_mem_ack); else pass_cnt++;
    tick; tick;
    total_cnt++; if (b_mem_rd !== 1'b1 || b_mem_addr !== 16'hFFFF) $display("FAIL wrap_hi_hold got rd=%b addr=%h exp 1 ffff", b_mem_rd, b_mem_addr); else pass_cnt++;
    tick;
    total_cnt++; if (b_mem_rd !== 1'b1 || b_mem_addr !== 16'h0000 || b_ir !== 32'h1234_0000) $display("FAIL wrap_lo got rd=%b addr=%h ir=%h exp 1 0000 12340000", b_mem_rd, b_mem_addr, b_ir); else pass_cnt++;
    tick; tick;
    total_cnt++; if (b_mem_rd !== 1'b1 || b_mem_addr !== 16'h0000) $display("FAIL wrap_lo_hold got rd=%b addr=%h exp 1 0000", b_mem_rd, b_mem_addr); else pass_cnt++;
    tick;
    total_cnt++; if (b_mem_rd !== 1'b0 || b_mem_addr !== 16'h0001 || b_ir !== 32'h1234_3456) $display("FAIL wrap_done got rd=%b addr=%h ir=%h exp 0 0001 12343456", b_mem_rd, b_mem_addr, b_ir); else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    mem[0] = 16'h0012; mem[1] = 16'h3456;
    a_delay = 0; ready1 = 1'b1;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    tick;
    a_delay = 100;
    total_cnt++; if (ir !== 32'h0012_0000 || mem_rd !== 1'b1) $display("FAIL abort_pre got ir=%h rd=%b exp 00120000 1", ir, mem_rd); else pass_cnt++;
    rst_n = 1'b0; start = 1'b1;
    tick;
    total_cnt++; if ({mem_rd, cs} !== 2'b00 || ir !== 32'h0 || mem_addr !== 16'h0000) $display("FAIL abort_fetch got rd=%b cs=%b ir=%h addr=%h exp 0 0 0 0000", mem_rd, cs, ir, mem_addr); else pass_cnt++;
    rst_n = 1'b1; start = 1'b0;
    tick;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL abort_idle got rd=%b exp 0", mem_rd); else pass_cnt++;
    a_delay = 0;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick; tick;
    ready1 = 1'b0; tick;
    rst_n = 1'b0; ready1 = 1'b1;
    tick;
    total_cnt++; if ({mem_rd, cs, halt} !== 3'b000 || ir !== 32'h0 || mem_addr !== 16'h0000) $display("FAIL abort_wait got rd=%b cs=%b halt=%b ir=%h addr=%h exp 0 0 0 0 0000", mem_rd, cs, halt, ir, mem_addr); else pass_cnt++;
    rst_n = 1'b1;
    tick;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL abort_wait_idle got rd=%b exp 0", mem_rd); else pass_cnt++;
  endtask

  task automatic test_timeout;
    mem[0] = 16'h0012; mem[1] = 16'h3456;
    a_delay = 0; ready1 = 1'b0;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick; tick;
    repeat (254) tick;
    total_cnt++; if (halt !== 1'b0 || err !== 1'b0) $display("FAIL tmo_early got halt=%b err=%b exp 0 0", halt, err); else pass_cnt++;
    tick;
`ifdef EU_TIMEOUT_EN
    total_cnt++; if (halt !== 1'b1 || err !== 1'b1) $display("FAIL tmo_fire got halt=%b err=%b exp 1 1", halt, err); else pass_cnt++;
    start = 1'b1; tick; start = 1'b0;
    total_cnt++; if (err !== 1'b1 || mem_rd !== 1'b1) $display("FAIL tmo_sticky got err=%b rd=%b exp 1 1", err, mem_rd); else pass_cnt++;
`else
    total_cnt++; if (halt !== 1'b0 || err !== 1'b0 || mem_rd !== 1'b0) $display("FAIL tmo_none got halt=%b err=%b rd=%b exp 0 0 0", halt, err, mem_rd); else pass_cnt++;
    repeat (50) tick;
    total_cnt++; if (halt !== 1'b0 || err !== 1'b0 || mem_rd !== 1'b0) $display("FAIL tmo_none_late got halt=%b err=%b rd=%b exp 0 0 0", halt, err, mem_rd); else pass_cnt++;
`endif
    ready1 = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; start = 1'b0; b_start = 1'b0; ready1 = 1'b1; b_ready1 = 1'b1;
    test_reset;
    test_arith_imm;
    test_arith_reg;
    test_nop_halt;
    test_wrap;
    test_reset_abort;
    test_timeout;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
